cb_dequantizer: RTL
===================

CB_DEQUANTIZER -- requirements
Module: cb_dequantizer

Interface
REQ-001 SHALL have parameter Q_MATRIX, default all 1, the Cb quantization table as int[0:7][0:7] in natural row-major order, legal entries 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning in_coef holds a valid coefficient.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a coefficient this cycle.
REQ-006 SHALL have port in_coef, input, signed 11, a quantized Cb coefficient in zigzag order, index 0 = DC.
REQ-007 SHALL have port out_valid, output, 1, meaning out_block holds a complete dequantized block.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts out_block.
REQ-009 SHALL have port out_block, output, signed 11 [0:7][0:7], dequantized coefficients in natural order for the IDCT.
REQ-010 SHALL have port out_sat, output, 1, meaning at least one coefficient of out_block was clipped.

Function
REQ-011 SHALL implement three states:
- FILL: in_ready=1, out_valid=0.
- DRAIN: in_ready=0, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-012 SHALL count transfers with a 6-bit index k, where a transfer is in_valid && in_ready; k increments per transfer.
REQ-013 SHALL move FILL->DRAIN on the transfer with k=63 and clear k to 0.
REQ-014 SHALL map index k to (row,col) through the standard JPEG zigzag table, e.g. k=1->(0,1), k=2->(1,0), k=63->(7,7).
REQ-015 SHALL compute product = in_coef * Q_MATRIX[row][col] as a signed 20-bit value, with the Q entry zero-extended.
REQ-016 SHALL clip the product to [-1024, +1023] and register it into buffer[row][col] exactly one cycle after the transfer (one pipeline stage).
REQ-017 SHALL make out_sat the OR of the clip events of the current block; out_sat is cleared when a new block's first transfer occurs.
REQ-018 SHALL spend exactly one cycle in DRAIN so the last write lands, then enter HOLD; out_valid therefore rises 2 cycles after the 64th transfer.
REQ-019 SHALL keep out_block and out_sat stable in HOLD until out_valid && out_ready.
REQ-020 SHALL go HOLD->FILL on the out handshake; in_ready=1 from the next cycle, so there is no same-cycle input/output overlap.
REQ-021 SHALL accept idle cycles with in_valid=0 anywhere mid-block without change to k or the buffer.
REQ-022 SHALL ignore in_valid while in DRAIN or HOLD, with no state change.
REQ-023 SHALL not clear buffer entries between blocks; every entry is overwritten once per block.

Reset
REQ-024 SHALL, while rst=0, force state=FILL, k=0, every buffer entry=0, out_valid=0, out_sat=0 and the pipeline register invalid.
REQ-025 SHALL hold in_ready=0 while rst=0 and assert it 1 from the first clock edge after rst is released.
REQ-026 SHALL discard a partial or held block on reset mid-operation; the next block starts at k=0.

Structure
REQ-027 SHALL take from shared package jpeg_pkg:
- typedef coef_t (signed 11),
- the constants COEF_MAX=1023 and COEF_MIN=-1024,
- the 64-entry zigzag row/col table ZIGZAG.
REQ-028 SHALL contain one sub-module, zigzag_index_map: combinational, 6-bit index in, 3-bit row and 3-bit col out, reusable by the Y/Cr dequantizers.
REQ-029 SHALL use no division; it needs one multiplier and 64 coefficient registers.

Verification
REQ-030 SHALL cover: Q all 1, inputs k=0..63 with value k -> out_block[zigzag(k)]=k, out_sat=0, out_valid exactly 2 cycles after the 64th transfer.
REQ-031 SHALL cover: Q = standard JPEG chroma table, DC=-26, AC k=1 = 3, rest 0 -> out_block[0][0]=-442, out_block[0][1]=54, others 0.
REQ-032 SHALL cover: Q[0][0]=99, DC=+20 (product 1980) and a second block with DC=-20 -> out_block[0][0]=1023 then -1024, out_sat=1 for both; a following block with DC=1 -> out_sat=0.
REQ-033 SHALL cover: random in_valid gaps of 0-3 cycles and out_ready held low 10 cycles -> results identical to the gapless run, in_ready=0 throughout HOLD, out_block stable.
REQ-034 SHALL cover: rst pulsed low after 30 transfers, then a full block of 64 sevens with Q all 2 -> every entry=14, and no stale values from before the reset.
REQ-035 SHALL cover: two back-to-back blocks with out_ready=1 -> in_ready returns 1 the cycle after the handshake, and the second block is correct.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder types and tables: coefficient type, clip limits,
// zigzag scan table and the dequantizer state encoding.
package jpeg_pkg;

   typedef logic signed [10:0] coef_t;

   localparam int COEF_MAX = 1023;
   localparam int COEF_MIN = -1024;

   // Zigzag position k -> natural index packed as {row[2:0], col[2:0]}
   localparam logic [5:0] ZIGZAG [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } deq_state_e;

endpackage

// File: rtl/zigzag_index_map.sv
// Combinational zigzag scan position to (row, col) lookup, shared by the
// Y/Cb/Cr dequantizers.
module zigzag_index_map
   import jpeg_pkg::*;
(
   input  logic [5:0] idx,
   output logic [2:0] row,
   output logic [2:0] col
);

   assign {row, col} = ZIGZAG[idx];

endmodule

// File: rtl/cb_dequantizer.sv
// Cb dequantizer: collects 64 zigzag-ordered coefficients, multiplies by the
// quantization table, clips to 11 bits and presents a natural-order block.
module cb_dequantizer
   import jpeg_pkg::*;
#(
   parameter int Q_MATRIX [0:7][0:7] = '{8{'{8{1}}}}
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  in_valid,
   output logic  in_ready,
   input  coef_t in_coef,
   output logic  out_valid,
   input  logic  out_ready,
   output coef_t out_block [0:7][0:7],
   output logic  out_sat
);

   function automatic coef_t clip_coef(input logic signed [19:0] p);
      if (p > COEF_MAX)      return coef_t'(COEF_MAX);
      else if (p < COEF_MIN) return coef_t'(COEF_MIN);
      else                   return coef_t'(p[10:0]);
   endfunction

   function automatic logic clip_hit(input logic signed [19:0] p);
      return (p > COEF_MAX) || (p < COEF_MIN);
   endfunction

   deq_state_e state_q, state_d;
   logic [5:0] k_q, k_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic       sat_q, sat_d;
   logic       wr_vld_q, wr_vld_d;
   logic [2:0] wr_row_q, wr_row_d;
   logic [2:0] wr_col_q, wr_col_d;
   coef_t      wr_coef_q, wr_coef_d;
   coef_t      buf_q [0:7][0:7];
   coef_t      buf_d [0:7][0:7];

   logic              xfer;
   logic [2:0]        zz_row, zz_col;
   logic [7:0]        q_ent;
   logic signed [19:0] prod;

   zigzag_index_map u_zigzag (
      .idx (k_q),
      .row (zz_row),
      .col (zz_col)
   );

   assign xfer  = in_valid && in_ready_q;

   // Stage 1: the registered coefficient is scaled and clipped on its way into the buffer
   assign q_ent = 8'(Q_MATRIX[wr_row_q][wr_col_q]);
   assign prod  = 20'(wr_coef_q) * $signed({12'd0, q_ent});

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      sat_d       = sat_q;
      wr_vld_d    = xfer;
      wr_row_d    = zz_row;
      wr_col_d    = zz_col;
      wr_coef_d   = in_coef;
      buf_d       = buf_q;

      if (wr_vld_q) begin
         buf_d[wr_row_q][wr_col_q] = clip_coef(prod);
         if (clip_hit(prod)) sat_d = 1'b1;
      end

      case (state_q)
         ST_FILL: begin
            in_ready_d = 1'b1;
            if (xfer) begin
               k_d = k_q + 6'd1;
               if (k_q == 6'd0) sat_d = 1'b0;
               if (k_q == 6'd63) begin
                  state_d    = ST_DRAIN;
                  in_ready_d = 1'b0;
                  k_d        = 6'd0;
               end
            end
         end
         // One cycle lets the final pipelined write land before the block is shown
         ST_DRAIN: begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d     = ST_FILL;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_FILL;
         k_q         <= 6'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         wr_vld_q    <= 1'b0;
         buf_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         wr_vld_q    <= wr_vld_d;
         buf_q       <= buf_d;
      end
   end

   // Stage 0: coefficient and its natural position captured at the transfer
   always_ff @(posedge clk) begin
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_coef_q <= wr_coef_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sat   = sat_q;
   assign out_block = buf_q;

endmodule
